// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use interlock, taken-branch flush and a
// multi-cycle multiply/divide stall sequencer with a saturating stall counter.
module hazard_control_unit #(
    parameter int unsigned MD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rt,
    input  logic [4:0]  if_id_rs,
    input  logic [4:0]  if_id_rt,
    input  logic        if_id_uses_rt,
    input  logic        ex_branch_taken,
    input  logic        md_start,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cycles
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // Issue cycle counts as the first stall, so the wait phase covers the rest.
    localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 32'd1);

    if (MD_CYCLES < 32'd2 || MD_CYCLES > 32'd16) begin : g_param_check
        $error("hazard_control_unit: MD_CYCLES must lie in 2..16");
    end

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;
    logic [15:0] stall_cnt_r;

    logic        hazard_s;
    logic        pc_write_s;
    logic        if_id_write_s;
    logic        id_ex_bubble_s;
    logic        if_id_flush_s;
    logic        id_ex_flush_s;
    logic        md_busy_s;
    logic        md_done_s;

    // Register 0 is hard-wired to zero, so a load into it never creates a dependency.
    function automatic logic load_hazard_f(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        logic rs_match;
        logic rt_match;
        rs_match = (ex_rt == rs);
        rt_match = uses_rt && (ex_rt == rt);
        return mem_read && (ex_rt != 5'd0) && (rs_match || rt_match);
    endfunction

    // Next-state and stall/flush decode from current state, count and pipeline inputs.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        pc_write_s     = 1'b1;
        if_id_write_s  = 1'b1;
        id_ex_bubble_s = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        md_busy_s      = 1'b0;
        md_done_s      = 1'b0;
        hazard_s       = load_hazard_f(id_ex_mem_read, id_ex_rt, if_id_rs,
                                       if_id_rt, if_id_uses_rt);
        case (state_r)
            RUN: begin
                if (ex_branch_taken) begin
                    if_id_flush_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                end else if (hazard_s) begin
                    pc_write_s     = 1'b0;
                    if_id_write_s  = 1'b0;
                    id_ex_bubble_s = 1'b1;
                end else if (md_start) begin
                    pc_write_s     = 1'b0;
                    if_id_write_s  = 1'b0;
                    id_ex_bubble_s = 1'b1;
                    cnt_nxt_s      = MD_LOAD;
                    state_nxt_s    = MD_WAIT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MD_WAIT: begin
                md_busy_s = 1'b1;
                if (cnt_r != 4'd0) begin
                    pc_write_s     = 1'b0;
                    if_id_write_s  = 1'b0;
                    id_ex_bubble_s = 1'b1;
                    cnt_nxt_s      = cnt_r - 4'd1;
                end else begin
                    md_done_s   = 1'b1;
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // State, wait counter and saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RUN;
            cnt_r       <= 4'd0;
            stall_cnt_r <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (!pc_write_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    // While reset is low the pipeline must run freely whatever the inputs say.
    assign pc_write     = pc_write_s | ~rst_n;
    assign if_id_write  = if_id_write_s | ~rst_n;
    assign id_ex_bubble = id_ex_bubble_s & rst_n;
    assign if_id_flush  = if_id_flush_s & rst_n;
    assign id_ex_flush  = id_ex_flush_s & rst_n;
    assign md_busy      = md_busy_s & rst_n;
    assign md_done      = md_done_s & rst_n;
    assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: a per-cycle queue model checked on
// every falling edge, plus hand-computed literal checks at key points.
module tb_hazard_control_unit;

    localparam int unsigned MD = 4;

    logic        clk;
    logic        rst_n;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic [4:0]  if_id_rs;
    logic [4:0]  if_id_rt;
    logic        if_id_uses_rt;
    logic        ex_branch_taken;
    logic        md_start;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_bubble;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        md_busy;
    logic        md_done;
    logic [15:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: pending per-cycle behaviour of an accepted mul/div (2'b10 stall, 2'b01 release).
    logic [1:0] md_q[$];
    int         model_stalls = 0;

    hazard_control_unit #(.MD_CYCLES(MD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .if_id_uses_rt  (if_id_uses_rt),
        .ex_branch_taken(ex_branch_taken),
        .md_start       (md_start),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_bubble   (id_ex_bubble),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .md_busy        (md_busy),
        .md_done        (md_done),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_hazard();
        return id_ex_mem_read && (id_ex_rt != 5'd0) &&
               ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
    endfunction

    // {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, md_busy, md_done}
    function automatic logic [6:0] model_out();
        if (!rst_n) return 7'b1100000;
        if (md_q.size() > 0) return (md_q[0] == 2'b10) ? 7'b0010010 : 7'b1100011;
        if (ex_branch_taken) return 7'b1101100;
        if (model_hazard() || md_start) return 7'b0010000;
        return 7'b1100000;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rst_n) begin
        md_q.delete();
        model_stalls = 0;
    end

    always @(posedge clk) begin
        logic [6:0] o;
        if (rst_n) begin
            o = model_out();
            if (!o[6] && model_stalls < 65535) model_stalls = model_stalls + 1;
            if (md_q.size() > 0) begin
                void'(md_q.pop_front());
            end else if (!ex_branch_taken && !model_hazard() && md_start) begin
                for (int i = 0; i < int'(MD) - 1; i++) md_q.push_back(2'b10);
                md_q.push_back(2'b01);
            end
        end
    end

    always @(negedge clk) begin
        logic [6:0] dut_o;
        logic [6:0] exp_o;
        dut_o = {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, md_busy, md_done};
        exp_o = model_out();
        n_cmp++;
        if (dut_o !== exp_o) begin
            n_bad++;
            $display("FAIL model_outputs: got %b expected %b at %0t", dut_o, exp_o, $time);
        end
        chk16("model_stall_cycles", stall_cycles, 16'(model_stalls));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        id_ex_mem_read  = 1'b0;
        id_ex_rt        = 5'd0;
        if_id_rs        = 5'd0;
        if_id_rt        = 5'd0;
        if_id_uses_rt   = 1'b0;
        ex_branch_taken = 1'b0;
        md_start        = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        clear_inputs();
        #1 rst_n = 1'b0;
        // Inputs that would stall/flush must be ignored in reset.
        ex_branch_taken = 1'b1;
        md_start        = 1'b1;
        id_ex_mem_read  = 1'b1;
        id_ex_rt        = 5'd5;
        if_id_rs        = 5'd5;
        repeat (3) step();
        #1;
        chk1("rst_pc_write", pc_write, 1'b1);
        chk1("rst_if_id_write", if_id_write, 1'b1);
        chk1("rst_flush", if_id_flush | id_ex_flush, 1'b0);
        chk1("rst_bubble", id_ex_bubble, 1'b0);
        chk16("rst_stall_cycles", stall_cycles, 16'd0);
        step();
        clear_inputs();
        rst_n = 1'b1;

        // Load-use on rs
        step();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
        #1;
        chk1("lu_pc_write", pc_write, 1'b0);
        chk1("lu_if_id_write", if_id_write, 1'b0);
        chk1("lu_bubble", id_ex_bubble, 1'b1);
        step();
        clear_inputs();
        #1;
        chk16("lu_stall_cycles", stall_cycles, 16'd1);
        chk1("lu_resume", pc_write, 1'b1);

        // r0 is never hazardous
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0; if_id_uses_rt = 1'b1;
        #1 chk1("r0_pc_write", pc_write, 1'b1);
        step();

        // rt gating
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd7; if_id_rs = 5'd3; if_id_rt = 5'd7; if_id_uses_rt = 1'b0;
        #1 chk1("rt_unused_pc_write", pc_write, 1'b1);
        step();
        if_id_uses_rt = 1'b1;
        #1 chk1("rt_used_pc_write", pc_write, 1'b0);
        step();
        clear_inputs();
        #1 chk16("rt_stall_cycles", stall_cycles, 16'd2);

        // Multiply issue: 4 stalled cycles then a release cycle
        md_start = 1'b1;
        #1;
        chk1("md_c1_pc_write", pc_write, 1'b0);
        chk1("md_c1_busy", md_busy, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            step();
            #1;
            chk1("md_stall_pc_write", pc_write, 1'b0);
            chk1("md_stall_busy", md_busy, 1'b1);
            chk1("md_stall_done", md_done, 1'b0);
            if (c == 4) chk16("md_after_3_edges", stall_cycles, 16'd5);
        end
        step();
        #1;
        chk1("md_rel_pc_write", pc_write, 1'b1);
        chk1("md_rel_busy", md_busy, 1'b1);
        chk1("md_rel_done", md_done, 1'b1);
        chk16("md_rel_stall_cycles", stall_cycles, 16'd6);
        step();
        md_start = 1'b0;
        #1;
        chk1("md_post_busy", md_busy, 1'b0);
        chk1("md_post_done", md_done, 1'b0);
        chk16("md_post_stall_cycles", stall_cycles, 16'd6);

        // Priority: branch over load hazard over md_start
        ex_branch_taken = 1'b1; id_ex_mem_read = 1'b1; id_ex_rt = 5'd9; if_id_rs = 5'd9; md_start = 1'b1;
        #1;
        chk1("pri_if_id_flush", if_id_flush, 1'b1);
        chk1("pri_id_ex_flush", id_ex_flush, 1'b1);
        chk1("pri_pc_write", pc_write, 1'b1);
        chk1("pri_bubble", id_ex_bubble, 1'b0);
        step();
        ex_branch_taken = 1'b0;
        #1;
        chk1("pri_lh_pc_write", pc_write, 1'b0);
        chk1("pri_lh_busy", md_busy, 1'b0);
        step();
        id_ex_mem_read = 1'b0;
        #1;
        chk1("pri_issue_pc_write", pc_write, 1'b0);
        chk1("pri_issue_busy", md_busy, 1'b0);
        step();
        ex_branch_taken = 1'b1;
        #1;
        chk1("pri_wait_busy", md_busy, 1'b1);
        chk1("pri_wait_branch_ignored", if_id_flush | id_ex_flush | pc_write, 1'b0);
        step();
        ex_branch_taken = 1'b0;
        step();
        step();
        #1;
        chk1("pri_rel_done", md_done, 1'b1);
        chk16("pri_rel_stall_cycles", stall_cycles, 16'd11);
        step();
        md_start = 1'b0;

        // Reset during MD_WAIT with cnt == 2
        md_start = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_pc_write", pc_write, 1'b1);
        chk1("mid_rst_busy", md_busy, 1'b0);
        chk1("mid_rst_done", md_done, 1'b0);
        chk16("mid_rst_stall_cycles", stall_cycles, 16'd0);
        step();
        step();
        md_start = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            #1;
            chk1("post_rst_no_done", md_done, 1'b0);
            chk1("post_rst_pc_write", pc_write, 1'b1);
        end

        // Saturation via a sustained load-use stall
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd4; if_id_rs = 5'd4;
        repeat (65534) step();
        #1 chk16("sat_65534", stall_cycles, 16'd65534);
        step();
        #1 chk16("sat_ffff", stall_cycles, 16'hFFFF);
        repeat (5) step();
        #1 chk16("sat_hold", stall_cycles, 16'hFFFF);
        clear_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
